// File: rtl/mux_rr_sel.sv
// N-to-1 word selector with a registered valid/ready output stage.
// Channels are picked either by an explicit index or by a round-robin scan.
module mux_rr_sel #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NPAD = 1 << SEL_W;

  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] rr_ptr_reg;

  // Channels padded to a power of two so that an out-of-range index reads
  // as a never-valid channel instead of needing a range compare.
  logic [WIDTH-1:0] chan_data [NPAD];
  logic [NPAD-1:0]  valid_pad;

  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < NUM_IN) begin : g_used
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        assign valid_pad[gi] = in_valid[gi];
      end else begin : g_unused
        assign chan_data[gi] = '0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // scan_idx[i] is the channel sitting i places after the pointer, mod NUM_IN.
  logic [SEL_W-1:0]  scan_idx [NUM_IN];
  logic [NUM_IN-1:0] scan_hit;

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_scan
      logic [SEL_W:0] sum;
      assign sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(gi);
      assign scan_idx[gi] = (sum >= (SEL_W+1)'(NUM_IN)) ?
                            SEL_W'(sum - (SEL_W+1)'(NUM_IN)) : sum[SEL_W-1:0];
      assign scan_hit[gi] = valid_pad[scan_idx[gi]];
    end
  endgenerate

  logic             rr_any;
  logic [SEL_W-1:0] rr_idx;

  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    // Descending so the smallest offset from the pointer wins.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (scan_hit[i]) begin
        rr_any = 1'b1;
        rr_idx = scan_idx[i];
      end
    end
  end

  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             xfer;
  logic [SEL_W-1:0] rr_ptr_next;

  assign grant_any   = mode ? rr_any : valid_pad[sel];
  assign grant_idx   = mode ? rr_idx : sel;
  assign load_en     = ~out_valid_reg | out_ready;
  assign xfer        = grant_any & load_en & ~reset;
  assign rr_ptr_next = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (xfer) begin
      out_data_reg  <= chan_data[grant_idx];
      out_sel_reg   <= grant_idx;
      out_valid_reg <= 1'b1;
      if (mode) rr_ptr_reg <= rr_ptr_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: an 8-channel instance driven from a vector table and
// a 6-channel instance exercising out-of-range select and pointer wrap.
module tb_mux_rr_sel;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [8*W-1:0] d8;
  logic [7:0]     v8, r8;
  logic           m8, ov8, ordy8;
  logic [2:0]     s8, os8;
  logic [W-1:0]   od8;

  logic [6*W-1:0] d6;
  logic [5:0]     v6, r6;
  logic           m6, ov6, ordy6;
  logic [2:0]     s6, os6;
  logic [W-1:0]   od6;

  mux_rr_sel #(.WIDTH(W), .NUM_IN(8)) dut8 (
    .clk(clk), .reset(reset), .in_data(d8), .in_valid(v8), .in_ready(r8),
    .mode(m8), .sel(s8), .out_data(od8), .out_sel(os8), .out_valid(ov8),
    .out_ready(ordy8));

  mux_rr_sel #(.WIDTH(W), .NUM_IN(6)) dut6 (
    .clk(clk), .reset(reset), .in_data(d6), .in_valid(v6), .in_ready(r6),
    .mode(m6), .sel(s6), .out_data(od6), .out_sel(os6), .out_valid(ov6),
    .out_ready(ordy6));

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   s;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] exp_ready;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[$];
  exp_t q8[$], q6[$];
  exp_t last8, last6;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic mode, input logic [2:0] sel,
                     input logic [7:0] valid, input logic ordy,
                     input logic [7:0] er, input logic ev);
    vec_t v;
    v.rst = rst; v.mode = mode; v.sel = sel; v.valid = valid; v.ordy = ordy;
    v.exp_ready = er; v.exp_valid = ev;
    tbl.push_back(v);
  endtask

  function automatic int onehot_idx(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step6(input string tag, input logic mode, input logic [2:0] sel,
                       input logic [5:0] valid, input logic [5:0] er, input logic ev);
    int   k;
    exp_t e;
    @(negedge clk);
    m6 = mode; s6 = sel; v6 = valid; ordy6 = 1'b1;
    #1;
    chk({tag, " in_ready"}, W'(r6), W'(er));
    k = onehot_idx({2'b00, er});
    if (k >= 0) begin
      e.d = 32'hB000_0000 + k;
      e.s = 3'(k);
      q6.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, W'(ov6), W'(ev));
    if (k >= 0 && q6.size() > 0) last6 = q6.pop_front();
    chk({tag, " out_data"}, od6, last6.d);
    chk({tag, " out_sel"}, W'(os6), W'(last6.s));
    $display("%s: in_ready=%b out_valid=%0d out_sel=%0d out_data=%h", tag, r6, ov6, os6, od6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   k;
    exp_t e;
    for (int i = 0; i < 8; i++) d8[i*W +: W] = 32'hA000_0000 + i;
    for (int i = 0; i < 6; i++) d6[i*W +: W] = 32'hB000_0000 + i;
    reset = 1'b1;
    v8 = 8'hFF; m8 = 1'b0; s8 = 3'd0; ordy8 = 1'b1;
    v6 = 6'h3F; m6 = 1'b0; s6 = 3'd0; ordy6 = 1'b1;
    last8 = '{d: '0, s: '0};
    last6 = '{d: '0, s: '0};

    // Reset held two cycles with every channel requesting, then idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin reset = 1'b0; v8 = 8'h00; v6 = 6'h00; end
      #1;
      chk("rst in_ready8", W'(r8), W'(0));
      chk("rst in_ready6", W'(r6), W'(0));
      @(posedge clk);
      #1;
      chk("rst out_valid", W'(ov8), W'(0));
      chk("rst out_data", od8, W'(0));
      chk("rst out_sel", W'(os8), W'(0));
      $display("reset cycle %0d: out_valid=%0d out_data=%h", c, ov8, od8);
    end

    // Direct select and backpressure.
    add(0, 0, 3'd5, 8'hFF, 1, 8'h20, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 3'd2, 8'hFF, 0, 8'h00, 1);
    add(0, 0, 3'd2, 8'hFF, 1, 8'h04, 1);
    // Round-robin over all channels, wrapping 7 -> 0.
    for (int i = 0; i < 10; i++) add(0, 1, 3'd0, 8'hFF, 1, 8'(1 << (i % 8)), 1);
    // Sparse requests, then a single requester.
    add(0, 1, 3'd0, 8'h44, 1, 8'h04, 1);
    add(0, 1, 3'd0, 8'h44, 1, 8'h40, 1);
    add(0, 1, 3'd0, 8'h44, 1, 8'h04, 1);
    add(0, 1, 3'd0, 8'h44, 1, 8'h40, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 3'd0, 8'h04, 1, 8'h04, 1);
    // Drain, load into an empty register while stalled, then hold.
    add(0, 1, 3'd0, 8'h00, 1, 8'h00, 0);
    add(0, 0, 3'd3, 8'h08, 0, 8'h08, 1);
    add(0, 1, 3'd0, 8'h00, 0, 8'h00, 1);
    // Round-robin stream from pointer 3, reset mid-stream, restart at 0.
    add(0, 1, 3'd0, 8'hFF, 1, 8'h08, 1);
    add(0, 1, 3'd0, 8'hFF, 1, 8'h10, 1);
    add(1, 1, 3'd0, 8'hFF, 1, 8'h00, 0);
    add(0, 1, 3'd0, 8'hFF, 1, 8'h01, 1);
    add(0, 1, 3'd0, 8'hFF, 1, 8'h02, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; m8 = tbl[i].mode; s8 = tbl[i].sel;
      v8 = tbl[i].valid; ordy8 = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), W'(r8), W'(tbl[i].exp_ready));
      k = onehot_idx(tbl[i].exp_ready);
      if (k >= 0) begin
        e.d = 32'hA000_0000 + k;
        e.s = 3'(k);
        q8.push_back(e);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), W'(ov8), W'(tbl[i].exp_valid));
      if (tbl[i].rst) last8 = '{d: '0, s: '0};
      else if (k >= 0 && q8.size() > 0) last8 = q8.pop_front();
      chk($sformatf("vec%0d out_data", i), od8, last8.d);
      chk($sformatf("vec%0d out_sel", i), W'(os8), W'(last8.s));
      $display("vec%0d: in_ready=%b out_valid=%0d out_sel=%0d out_data=%h",
               i, r8, ov8, os8, od8);
    end
    reset = 1'b0;
    v8 = 8'h00;

    // Six-channel instance: out-of-range selects and scan wrap 5 -> 0.
    step6("n6 sel1", 0, 3'd1, 6'h3F, 6'h02, 1);
    step6("n6 sel7", 0, 3'd7, 6'h3F, 6'h00, 0);
    step6("n6 sel6", 0, 3'd6, 6'h3F, 6'h00, 0);
    step6("n6 rr0", 1, 3'd0, 6'h21, 6'h01, 1);
    step6("n6 rr5", 1, 3'd0, 6'h21, 6'h20, 1);
    step6("n6 rrwrap", 1, 3'd0, 6'h21, 6'h01, 1);
    step6("n6 drain", 0, 3'd7, 6'h3F, 6'h00, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
